// File: rtl/apb_periph_pkg.sv
// ============================================================================
// Module   : apb_periph_pkg
// Brief    : Shared constants and checker state type for the APB peripheral bank
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_periph_pkg;

    localparam int NUM_SLV = 3;
    localparam int NUM_REG = 8;
    localparam int IDX_W   = $clog2(NUM_REG);
    localparam int NUM_RW  = 6;
    localparam int CNT_W   = 16;

    localparam logic [IDX_W-1:0] IDX_CNT = IDX_W'(6);
    localparam logic [IDX_W-1:0] IDX_ID  = IDX_W'(7);

    localparam logic [31:0] ID_BASE = 32'hA9B0_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_st_e;

endpackage

`default_nettype wire

// File: rtl/apb_reg_slave.sv
// ============================================================================
// Module   : apb_reg_slave
// Brief    : One APB slave: six RW words, a read-only write counter and an ID word
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_reg_slave #(
    parameter int          NUM_REG  = apb_periph_pkg::NUM_REG,
    parameter logic [31:0] ID_VALUE = apb_periph_pkg::ID_BASE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [$clog2(NUM_REG)-1:0] i_idx,
    input  logic [31:0]                i_wdata,
    output logic [31:0]                o_rdata
);
    import apb_periph_pkg::*;

    localparam int IW = $clog2(NUM_REG);
    localparam logic [IW-1:0] c_IDX_CNT = IW'(IDX_CNT);
    localparam logic [IW-1:0] c_IDX_ID  = IW'(IDX_ID);
    localparam logic [IW-1:0] c_NUM_RW  = IW'(NUM_RW);

    logic [31:0]      r_regs [NUM_RW];
    logic [CNT_W-1:0] r_cnt;
    logic             w_rw_hit;

    assign w_rw_hit = (i_idx < c_NUM_RW);

    // Only RW words are written and counted; the counter wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt <= '0;
        end else if (i_wr_en && w_rw_hit) begin
            r_regs[i_idx] <= i_wdata;
            r_cnt         <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_idx == c_IDX_CNT) begin
            o_rdata = {{(32-CNT_W){1'b0}}, r_cnt};
        end else if (i_idx == c_IDX_ID) begin
            o_rdata = ID_VALUE;
        end else if (w_rw_hit) begin
            o_rdata = r_regs[i_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_periph_bank.sv
// ============================================================================
// Module   : apb_periph_bank
// Brief    : APB register bank behind the AHB-to-APB bridge; optional protocol
//            checker enabled by defining APB_PROTO_CHECK_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_periph_bank #(
    parameter int          NUM_SLV = apb_periph_pkg::NUM_SLV,
    parameter int          NUM_REG = apb_periph_pkg::NUM_REG,
    parameter logic [31:0] ID_BASE = apb_periph_pkg::ID_BASE
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [NUM_SLV-1:0] Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [31:0]        Paddr,
    input  logic [31:0]        Pwdata,
    output logic [31:0]        Prdata,
    output logic               proto_err
);
    import apb_periph_pkg::*;

    localparam int IW = $clog2(NUM_REG);

    logic [IW-1:0]      w_idx;
    logic               w_onehot;
    logic               w_rd_setup;
    logic [NUM_SLV-1:0] w_wr_en;
    logic [31:0]        w_slv_rdata [NUM_SLV];
    logic [31:0]        w_rd_mux;
    logic [31:0]        r_prdata;

    assign w_idx      = Paddr[IW+1:2];
    assign w_onehot   = $onehot(Pselx);
    assign w_rd_setup = (Pselx != '0) && !Penable && !Pwrite;

    generate
        for (genvar s = 0; s < NUM_SLV; s++) begin : g_slv
            assign w_wr_en[s] = (Pselx == (NUM_SLV'(1) << s)) && Penable && Pwrite;

            apb_reg_slave #(
                .NUM_REG  (NUM_REG),
                .ID_VALUE (ID_BASE | 32'(s))
            ) u_slv (
                .clk     (Hclk),
                .rst_n   (Hresetn),
                .i_wr_en (w_wr_en[s]),
                .i_idx   (w_idx),
                .i_wdata (Pwdata),
                .o_rdata (w_slv_rdata[s])
            );
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (Pselx[s]) begin
                w_rd_mux = w_rd_mux | w_slv_rdata[s];
            end
        end
    end

    // Read data is captured at SETUP so it stays stable across ACCESS
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_prdata <= '0;
        end else if (w_rd_setup) begin
            r_prdata <= w_onehot ? w_rd_mux : 32'h0;
        end
    end

    assign Prdata = r_prdata;

`ifdef APB_PROTO_CHECK_EN
    apb_st_e            r_state;
    apb_st_e            w_state_nxt;
    logic [31:0]        r_paddr;
    logic [31:0]        r_pwdata;
    logic               r_pwrite;
    logic [NUM_SLV-1:0] r_psel;
    logic               r_mask;
    logic               r_proto_err;
    logic               w_viol;
    logic               w_mask_nxt;
    logic               w_valid_setup;
    logic               w_changed;

    assign w_valid_setup = w_onehot && !Penable;
    assign w_changed     = (Paddr != r_paddr) || (Pwrite != r_pwrite) || (Pselx != r_psel) ||
                           (r_pwrite && (Pwdata != r_pwdata));

    always_comb begin
        w_state_nxt = r_state;
        w_viol      = (Pselx != '0) && !w_onehot;
        case (r_state)
            IDLE: begin
                if (Penable) begin
                    w_viol = 1'b1;
                end else if (w_valid_setup) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (Pselx == '0) begin
                    w_viol = 1'b1;
                end else if (Penable) begin
                    if (w_changed) begin
                        w_viol = 1'b1;
                    end
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (Pselx == '0) begin
                    w_state_nxt = IDLE;
                end else if (w_valid_setup) begin
                    w_state_nxt = SETUP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_viol) begin
            w_state_nxt = w_valid_setup ? SETUP : IDLE;
        end
        // One report per broken transfer: mask until the bus idles or restarts cleanly
        w_mask_nxt = r_mask;
        if (w_viol) begin
            w_mask_nxt = 1'b1;
        end else if ((Pselx == '0) || w_valid_setup) begin
            w_mask_nxt = 1'b0;
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state     <= IDLE;
            r_mask      <= 1'b0;
            r_proto_err <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_proto_err <= w_viol && !r_mask;
            if (w_valid_setup) begin
                r_paddr  <= Paddr;
                r_pwdata <= Pwdata;
                r_pwrite <= Pwrite;
                r_psel   <= Pselx;
            end
        end
    end

    assign proto_err = r_proto_err;
`else
    logic w_unused_paddr;

    assign w_unused_paddr = ^{Paddr[31:IW+2], Paddr[1:0]};
    assign proto_err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apb_periph_bank.sv
// ============================================================================
// Module   : tb_apb_periph_bank
// Brief    : Scoreboard bench for apb_periph_bank against an array-based model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_periph_bank;

`ifdef APB_PROTO_CHECK_EN
    localparam int PC = 1;
`else
    localparam int PC = 0;
`endif

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic [2:0]  Pselx = 3'b000;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = 32'h0;
    logic [31:0] Pwdata = 32'h0;
    logic [31:0] Prdata;
    logic        proto_err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int err_base = 0;

    logic [31:0] m_regs [3][6];
    int          m_cnt [3];
    logic [31:0] exp_q [$];
    string       nm_q [$];

    apb_periph_bank dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .proto_err (proto_err)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(int s, int idx);
        if (idx == 7) return 32'hA9B0_0000 | 32'(s);
        if (idx == 6) return 32'(m_cnt[s] % 65536);
        return m_regs[s][idx];
    endfunction

    function automatic int sel2slv(logic [2:0] sel);
        for (int i = 0; i < 3; i++) begin
            if (sel == 3'(1 << i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 6; i++) m_regs[s][i] = 32'h0;
            m_cnt[s] = 0;
        end
    endtask

    task automatic idle(int n);
        Pselx   = 3'b000;
        Penable = 1'b0;
        repeat (n) @(posedge Hclk);
        #1;
    endtask

    task automatic xfer(logic [2:0] sel, logic wr, int idx, logic [31:0] d);
        logic [31:0] r;
        int          s;
        r       = $urandom();
        s       = sel2slv(sel);
        Pselx   = sel;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = {r[31:5], 3'(idx), r[1:0]};
        Pwdata  = wr ? d : $urandom();
        if (wr) begin
            if (s >= 0 && idx < 6) begin
                m_regs[s][idx] = d;
                m_cnt[s]++;
            end
        end else begin
            exp_q.push_back(s >= 0 ? ref_read(s, idx) : 32'h0);
            nm_q.push_back($sformatf("rd sel=%b idx=%0d", sel, idx));
        end
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    task automatic chk_err(string nm, int pulses);
        idle(3);
        chk(nm, 32'(err_seen - err_base), 32'(pulses * PC));
        err_base = err_seen;
    endtask

    // Monitor: every read ACCESS cycle presents data to the bridge
    always @(negedge Hclk) begin
        if (proto_err === 1'b1) err_seen++;
        if (Hresetn && Pselx != 3'b000 && Penable && !Pwrite) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected read: got %h expected no read", Prdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                chk(n, Prdata, e);
            end
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          c;
        int          n;
        logic [31:0] d;

        model_reset();
        repeat (3) @(posedge Hclk);
        #1;
        Hresetn = 1'b1;
        chk("reset prdata", Prdata, 32'h0);
        chk("reset proto_err", {31'b0, proto_err}, 32'h0);

        for (int s = 0; s < 3; s++) xfer(3'(1 << s), 1'b0, 7, 32'h0);

        xfer(3'b010, 1'b1, 2, 32'hDEAD_BEEF);
        xfer(3'b010, 1'b0, 2, 32'h0);
        xfer(3'b010, 1'b0, 6, 32'h0);
        xfer(3'b001, 1'b0, 2, 32'h0);
        xfer(3'b100, 1'b0, 2, 32'h0);
        xfer(3'b010, 1'b0, 2, 32'h0);
        xfer(3'b001, 1'b1, 4, 32'h1111_2222);
        idle(2);
        chk("prdata hold over write/idle", Prdata, 32'hDEAD_BEEF);

        xfer(3'b100, 1'b1, 7, 32'h5555_AAAA);
        xfer(3'b100, 1'b1, 6, 32'h0000_1234);
        xfer(3'b100, 1'b0, 7, 32'h0);
        xfer(3'b100, 1'b0, 6, 32'h0);
        chk_err("no err on clean traffic", 0);

        xfer(3'b011, 1'b1, 0, 32'hCAFE_0000);
        chk_err("multihot write err", 1);
        xfer(3'b001, 1'b0, 0, 32'h0);
        xfer(3'b010, 1'b0, 0, 32'h0);
        xfer(3'b011, 1'b0, 0, 32'h0);
        chk_err("multihot read err", 1);

        Pselx   = 3'b001;
        Pwrite  = 1'b1;
        Penable = 1'b1;
        Paddr   = 32'h0000_001C;
        Pwdata  = 32'hFFFF_FFFF;
        @(posedge Hclk); #1;
        chk_err("penable in idle err", 1);

        a       = $urandom();
        a[4:2]  = 3'd1;
        Pselx   = 3'b010;
        Pwrite  = 1'b0;
        Penable = 1'b0;
        Paddr   = a;
        exp_q.push_back(ref_read(1, 1));
        nm_q.push_back("rd paddr-change");
        @(posedge Hclk); #1;
        Penable = 1'b1;
        Paddr   = {a[31:5], 3'd2, a[1:0]};
        @(posedge Hclk); #1;
        chk_err("paddr change err", 1);

        repeat (300) begin
            xfer(3'(1 << $urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), $urandom());
            n = int'($urandom_range(0, 2));
            if (n > 0) idle(n);
        end
        chk_err("no err on random traffic", 0);

        xfer(3'b001, 1'b1, 3, 32'h55AA_55AA);
        Pselx   = 3'b001;
        Pwrite  = 1'b1;
        Penable = 1'b0;
        Paddr   = 32'h0000_000C;
        Pwdata  = 32'h1234_5678;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        Hresetn = 1'b0;
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        Pselx   = 3'b000;
        Penable = 1'b0;
        model_reset();
        chk("prdata after mid-xfer reset", Prdata, 32'h0);
        xfer(3'b001, 1'b0, 3, 32'h0);
        xfer(3'b001, 1'b0, 6, 32'h0);
        chk_err("no err after reset", 0);

        c = m_cnt[0] % 65536;
        n = 65535 - c;
        d = $urandom();
        if (n > 0) begin
            Pselx   = 3'b001;
            Pwrite  = 1'b1;
            Penable = 1'b0;
            Paddr   = 32'h0;
            Pwdata  = d;
            @(posedge Hclk); #1;
            Penable = 1'b1;
            repeat (n) @(posedge Hclk);
            #1;
            Pselx   = 3'b000;
            Penable = 1'b0;
            m_regs[0][0] = d;
            m_cnt[0] += n;
        end
        xfer(3'b001, 1'b0, 6, 32'h0);
        xfer(3'b001, 1'b0, 0, 32'h0);
        xfer(3'b001, 1'b1, 5, 32'h0BAD_F00D);
        xfer(3'b001, 1'b0, 6, 32'h0);
        xfer(3'b001, 1'b0, 5, 32'h0);
        chk_err("no err on held access", 0);

        idle(2);
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_periph_bank.md
# apb_periph_bank

Downstream APB peripheral bank for the AHB-to-APB bridge. It consumes the bridge's APB outputs (`Pselx`, `Penable`, `Pwrite`, `Paddr`, `Pwdata`) and returns `Prdata`, completing the read path back to `Hrdata`. It holds three register slaves, one per `Pselx` bit, each with eight 32-bit word registers. An optional protocol checker flags APB sequencing violations.

## Interface
Parameters:
- `NUM_SLV`, 3: slave count; equals the `Pselx` width.
- `NUM_REG`, 8: registers per slave; the index is `Paddr[4:2]`.
- `ID_BASE`, 32'hA9B0_0000: base of the read-only ID value.

Ports:
- `Hclk`  in  1  single clock.
- `Hresetn`  in  1  reset, synchronous, active-low.
- `Pselx`  in  3  one-hot slave select from the bridge.
- `Penable`  in  1  APB enable (ACCESS phase).
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  byte address; only `[4:2]` is decoded.
- `Pwdata`  in  32  write data.
- `Prdata`  out  32  read data to the bridge.
- `proto_err`  out  1  one-cycle pulse on an APB protocol violation (macro-dependent).

## Operation
- Slave s is selected when `Pselx == 1<<s`. Any multi-hot `Pselx` is ignored: no write occurs, and `Prdata` loads 0 at SETUP.
- Register map per slave:
  - idx 0–5: read/write, reset value 0.
  - idx 6: read-only 16-bit write counter, zero-extended.
  - idx 7: read-only ID, `ID_BASE | s`.
- Write: takes effect on the edge where `Pselx` is valid, `Penable=1` and `Pwrite=1`. The target register takes `Pwdata`.
  - A write to idx 0–5 increments that slave's counter by 1. The counter wraps from 0xFFFF to 0x0000.
  - A write to idx 6 or 7 is ignored and not counted.
- Read: on the SETUP edge (`Pselx` valid, `Penable=0`, `Pwrite=0`), the addressed register is registered into `Prdata`. `Prdata` is therefore stable throughout ACCESS.
- `Prdata` holds its value at all other times, including idle cycles and writes.
- `Paddr` bits other than `[4:2]` are don't-care.

## Timing
- Reset, synchronous, while `Hresetn=0` at the edge: all RW registers 0, counters 0, `Prdata`=0, `proto_err`=0, checker FSM in IDLE.
- Reset asserted mid-transfer aborts the transfer. A write in that same cycle is dropped.
- Read latency: `Prdata` is valid 1 cycle after the SETUP edge, which is the full ACCESS cycle. There are no wait states; the bridge has no PREADY.
- Write latency: the register updates on the ACCESS edge. A read SETUP in the next cycle returns the new value.
- Back-to-back transfers (ACCESS followed directly by SETUP) are supported at full rate.
- Checker FSM (IDLE, SETUP, ACCESS):
  - IDLE→SETUP when `Pselx`≠0 and `Penable`=0.
  - SETUP→ACCESS when `Penable`=1.
  - ACCESS→SETUP on a new select with `Penable`=0.
  - ACCESS→IDLE when `Pselx`=0.
- Violations, each causing `proto_err`=1 for exactly one cycle on the following edge:
  - `Penable`=1 while in IDLE.
  - `Pselx` not one-hot and nonzero.
  - `Paddr`, `Pwrite`, `Pselx` or (for writes) `Pwdata` changing between SETUP and ACCESS.
  - SETUP followed by `Pselx`=0.
- On a violation the FSM returns to IDLE, or to SETUP if a valid setup is present that cycle.

## Configuration
- `APB_PROTO_CHECK_EN` defined: the checker FSM and `proto_err` logic are compiled in.
- Not defined: the FSM is absent and `proto_err` is tied 0. Register and read behaviour are identical in both builds.

## Structure
- Package `apb_periph_pkg` holds:
  - `NUM_SLV`, `NUM_REG`.
  - Register index constants `IDX_CNT=6` and `IDX_ID=7`.
  - `ID_BASE`.
  - The checker state enum `apb_st_e` {IDLE, SETUP, ACCESS}.
- Sub-module `apb_reg_slave` implements one slave's registers, counter and read mux. It is instantiated `NUM_SLV` times.
- The top level does select decode, the `Prdata` register, and the checker.

## Test plan
- Reset, then read idx 7 of slaves 0, 1, 2 → `Prdata` = 0xA9B0_0000, 0xA9B0_0001, 0xA9B0_0002.
- Write 0xDEAD_BEEF to slave1 idx 2, then read it back → 0xDEAD_BEEF; slave1 idx 6 = 1; slave0 and slave2 idx 2 = 0.
- Write to slave2 idx 7 and idx 6 → both ignored; idx 6 still reads 0.
- Preload the slave0 counter to 0xFFFF via 65535 writes, then write once more → idx 6 reads 0 (wrap).
- `Pselx`=3'b011 with a write → no register changes; a read → `Prdata`=0. With the macro defined, `proto_err` pulses once.
- With the macro defined:
  - `Penable`=1 in IDLE → one `proto_err` pulse.
  - `Paddr` changing between SETUP and ACCESS → one pulse.
  - Reset asserted in ACCESS of a write → the write is dropped.
